// File: rtl/fetch_decode_unit.sv
// Fetch/decode control for a simple sequencer: IDLE -> FETCH -> DECODE -> EXEC.
// Opcodes 0xC jump, 0xD skip, 0xE return, 0xF halt; all others sequential.
// Optional build macro FETCH_TIMEOUT_EN adds a fetch wait counter and a FAULT state.
module fetch_decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pc,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic        ex_flag,
    output logic [1:0]  jmp_en,
    output logic [11:0] jmp_addr,
    output logic        ret_flag,
    output logic        halted,
    output logic [15:0] instr_count,
    output logic        fault
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam logic [3:0]  OPC_JMP  = 4'hC;
    localparam logic [3:0]  OPC_SKIP = 4'hD;
    localparam logic [3:0]  OPC_RET  = 4'hE;
    localparam logic [3:0]  OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
`ifdef FETCH_TIMEOUT_EN
        ,
        FAULT  = 3'd5
`endif
    } state_t;

    state_t              state, state_d;
    logic                mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   ir_d;
    logic                ex_flag_d;
    logic [1:0]          jmp_en_d;
    logic [ADDR_W-1:0]   jmp_addr_d;
    logic                ret_flag_d;
    logic                halted_d;
    logic [CNT_W-1:0]    instr_count_d;
    logic [3:0]          opcode;

    assign opcode = ir[15:12];

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt, wait_cnt_d;
    logic       fault_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr;
        ir_d          = ir;
        ex_flag_d     = 1'b0;
        jmp_en_d      = jmp_en;
        jmp_addr_d    = jmp_addr;
        ret_flag_d    = 1'b0;
        halted_d      = halted;
        instr_count_d = instr_count;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d    = wait_cnt;
        fault_d       = fault;
`endif
        case (state)
            IDLE: begin
                mem_addr_d = pc;
                mem_req_d  = 1'b1;
                state_d    = FETCH;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_d = 4'd0;
`endif
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // The 15th unanswered cycle is the last one allowed
                    if (wait_cnt == 4'd14) begin
                        wait_cnt_d = 4'd15;
                        fault_d    = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt + 4'd1;
                        mem_req_d  = 1'b1;
                    end
`else
                    mem_req_d = 1'b1;
`endif
                end
            end
            DECODE: begin
                if (opcode == OPC_HALT) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    ex_flag_d = 1'b1;
                    state_d   = EXEC;
                    case (opcode)
                        OPC_JMP: begin
                            jmp_en_d   = 2'b11;
                            jmp_addr_d = ir[11:0];
                        end
                        OPC_SKIP: jmp_en_d = 2'b10;
                        OPC_RET: begin
                            jmp_en_d   = 2'b01;
                            ret_flag_d = 1'b1;
                        end
                        default:  jmp_en_d = 2'b00;
                    endcase
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (instr_count != {CNT_W{1'b1}})
                    instr_count_d = instr_count + CNT_W'(1);
            end
            HALT:    state_d = HALT;
`ifdef FETCH_TIMEOUT_EN
            FAULT:   state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            ir          <= '0;
            ex_flag     <= 1'b0;
            jmp_en      <= 2'b00;
            jmp_addr    <= '0;
            ret_flag    <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            ir          <= ir_d;
            ex_flag     <= ex_flag_d;
            jmp_en      <= jmp_en_d;
            jmp_addr    <= jmp_addr_d;
            ret_flag    <= ret_flag_d;
            halted      <= halted_d;
            instr_count <= instr_count_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Fetch timeout counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            fault    <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_d;
            fault    <= fault_d;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 The block SHALL have a clock input clk (1 bit); all state updates on its rising edge.
REQ-002 The block SHALL have a reset input rst (1 bit); reset is synchronous and active-high.
REQ-003 The block SHALL have input pc (12 bits): the current program counter from the PC stage.
REQ-004 The block SHALL have output mem_req (1 bit): program-memory read request.
REQ-005 The block SHALL have output mem_addr (12 bits): the read address, held stable while mem_req=1.
REQ-006 The block SHALL have input mem_ack (1 bit): the read has completed, with mem_rdata valid in the same cycle.
REQ-007 The block SHALL have input mem_rdata (16 bits): the instruction word.
REQ-008 The block SHALL have output ir (16 bits): the latched instruction register.
REQ-009 The block SHALL have output ex_flag (1 bit): a one-cycle pulse that advances the PC stage.
REQ-010 The block SHALL have output jmp_en (2 bits): 00 = sequential, 01 = return, 10 = skip, 11 = jump.
REQ-011 The block SHALL have output jmp_addr (12 bits): the jump target.
REQ-012 The block SHALL have output ret_flag (1 bit): a return instruction is executing.
REQ-013 The block SHALL have output halted (1 bit): the HALT state has been reached.
REQ-014 The block SHALL have output instr_count (16 bits): the number of retired instructions.
REQ-015 The block SHALL have output fault (1 bit): a fetch timeout has occurred (only when FETCH_TIMEOUT_EN is defined; otherwise tied to 0).

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, HALT and FAULT.
REQ-017 In IDLE, the block SHALL load mem_addr<=pc and go to FETCH on the next edge (the IDLE dwell is exactly 1 cycle).
REQ-018 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be unchanged; on an edge with mem_ack=1, the block SHALL load ir<=mem_rdata and go to DECODE; otherwise it stays in FETCH.
REQ-019 mem_ack outside FETCH SHALL be ignored; a pc change during FETCH SHALL NOT alter mem_addr.
REQ-020 In DECODE, the block SHALL register the decode of ir[15:12] and go to EXEC.
REQ-021 Opcode 0xC SHALL decode to jmp_en=11 and jmp_addr=ir[11:0].
REQ-022 Opcode 0xD SHALL decode to jmp_en=10.
REQ-023 Opcode 0xE SHALL decode to jmp_en=01 and ret_flag=1.
REQ-024 Opcode 0xF SHALL be treated as HALT.
REQ-025 All other opcodes SHALL decode to jmp_en=00 and ret_flag=0.
REQ-026 In EXEC, ex_flag SHALL be 1 for exactly one cycle, with jmp_en, jmp_addr and ret_flag valid in that same cycle; the next state is IDLE.
REQ-027 For opcode 0xF, DECODE SHALL go to HALT instead of EXEC: ex_flag is not pulsed, halted=1, and the block stays in HALT until rst.
REQ-028 Outside EXEC, ex_flag SHALL be 0 and ret_flag SHALL be 0; jmp_en and jmp_addr SHALL hold their last decoded values.
REQ-029 instr_count SHALL increment by 1 on each EXEC cycle and saturate at 0xFFFF (no wrap); HALT SHALL NOT be counted.
REQ-030 With zero-wait memory (mem_ack high in the first FETCH cycle), throughput SHALL be one instruction per 4 cycles; each wait cycle adds 1 cycle.
REQ-031 Since the PC stage updates pc on the EXEC edge, the IDLE sample SHALL capture the updated pc.

Reset
REQ-032 rst=1 SHALL force state=IDLE, mem_req=0, mem_addr=0, ir=0, ex_flag=0, jmp_en=00, jmp_addr=0, ret_flag=0, halted=0, instr_count=0 and fault=0 on the next edge.
REQ-033 Reset SHALL have priority over every other event, including a mem_ack in the same edge; an outstanding request is abandoned and mem_req=0 the cycle after.

Configuration
REQ-034 When FETCH_TIMEOUT_EN is defined, a 4-bit wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; on reaching 15 without ack the block SHALL go to FAULT, with fault=1 and mem_req=0, and remain there until rst.
REQ-035 An ack in the same cycle the wait counter reaches 15 SHALL win, and the block goes to DECODE.
REQ-036 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, the FAULT state and counter SHALL be absent, and fault SHALL be constant 0.

Verification
REQ-037 Reset, pc=0x000, zero-wait memory returns 0x1234 -> mem_addr=0x000, ir=0x1234, jmp_en=00, ex_flag pulses in cycle 4, instr_count=1.
REQ-038 mem_rdata=0xC2A5 -> EXEC cycle shows jmp_en=11, jmp_addr=0x2A5, ex_flag=1; next IDLE samples pc=0x2A5.
REQ-039 mem_rdata=0xE000 -> ret_flag=1 and jmp_en=01 during EXEC only; mem_rdata=0xF000 -> halted=1, no ex_flag, count unchanged, no further mem_req.
REQ-040 mem_ack delayed 3 cycles while pc toggles -> mem_addr constant, 7-cycle instruction; rst asserted mid-FETCH -> mem_req=0 and all outputs at reset values next cycle.
REQ-041 With FETCH_TIMEOUT_EN defined and no ack -> fault=1 after 15 FETCH cycles, mem_req=0; ack on the 15th cycle -> normal DECODE, fault=0.
